// File: rtl/prescaler_multi_if.sv
`timescale 1ns/1ps
// prescaler_multi_if
//   Control/status bundle for the multi-channel clock-enable generator.
//   master: drives ratio, mode, load, start, stop, sync_all; observes en, busy.
//   slave : the prescaler itself; observes the controls, drives en and busy.
//   ratio packs CH fields of W bits; channel i lives in ratio[i*W +: W].
interface prescaler_multi_if #(
  parameter int CH = 4,
  parameter int W  = 16
);
  logic [CH*W-1:0] ratio;
  logic [CH-1:0]   mode;
  logic [CH-1:0]   load;
  logic [CH-1:0]   start;
  logic [CH-1:0]   stop;
  logic            sync_all;
  logic [CH-1:0]   en;
  logic [CH-1:0]   busy;

  modport master (
    output ratio, mode, load, start, stop, sync_all,
    input  en, busy
  );

  modport slave (
    input  ratio, mode, load, start, stop, sync_all,
    output en, busy
  );
endinterface

// File: rtl/prescaler_multi.sv
`timescale 1ns/1ps
// prescaler_multi
//   Multi-channel, runtime-programmable clock-enable generator (clk50m domain).
//   Each channel emits a one-cycle en pulse every R clocks (periodic) or a single
//   pulse (one-shot). Channels are fully independent; each owns its own counter.
// Ports
//   clk50m : system clock, all logic on posedge
//   rst    : synchronous reset, active-high
//   bus    : prescaler_multi_if.slave
//              ratio[CH*W]  per-channel ratio R (captured on load)
//              mode[CH]     0 periodic / 1 one-shot (captured on load)
//              load[CH]     capture ratio/mode into channel shadow registers
//              start[CH]    (re)start channel from full count
//              stop[CH]     halt channel, suppress any pulse due this edge
//              sync_all     restart every running channel from full count
//              en[CH]       registered one-cycle enable pulse
//              busy[CH]     channel running
module prescaler_multi #(
  parameter int CH        = 4,
  parameter int W         = 16,
  parameter int RATIO_RST = 50000,
  parameter int AUTORUN   = 1
) (
  input logic                clk50m,
  input logic                rst,
  prescaler_multi_if.slave   bus
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [W-1:0] RST_RATIO = W'(RATIO_RST);
  localparam logic [W-1:0] RST_CNT   = RST_RATIO - W'(1);
  // A zero reset ratio can never pulse, so such a channel comes out of reset idle.
  localparam state_t       RST_STATE = ((AUTORUN != 0) && (RATIO_RST != 0)) ? ST_RUN : ST_IDLE;

  for (genvar g = 0; g < CH; g++) begin : g_ch
    state_t       state;
    logic [W-1:0] ratio_q;
    logic [W-1:0] cnt;
    logic         mode_q;
    logic         en_q;

    logic [W-1:0] ratio_in;
    logic [W-1:0] start_ratio;
    logic         restart;

    always_comb begin
      ratio_in    = bus.ratio[g*W +: W];
      // load is applied in parallel with start/sync, so a restart on the same
      // edge must already use the freshly loaded ratio.
      start_ratio = bus.load[g] ? ratio_in : ratio_q;
      // sync_all only touches channels that are currently running.
      restart     = bus.start[g] | (bus.sync_all & (state == ST_RUN));
    end

    always_ff @(posedge clk50m) begin
      if (rst) begin
        ratio_q <= RST_RATIO;
        mode_q  <= 1'b0;
        cnt     <= RST_CNT;
        state   <= RST_STATE;
        en_q    <= 1'b0;
      end else begin
        if (bus.load[g]) begin
          ratio_q <= ratio_in;
          mode_q  <= bus.mode[g];
        end

        if (bus.stop[g]) begin
          state <= ST_IDLE;
          en_q  <= 1'b0;
        end else if (restart) begin
          en_q <= 1'b0;
          if (start_ratio == '0) begin
            state <= ST_IDLE;
          end else begin
            state <= ST_RUN;
            cnt   <= start_ratio - W'(1);
          end
        end else if (state == ST_RUN) begin
          if (cnt == '0) begin
            en_q <= 1'b1;
            // Reload uses ratio_q as it stands now: a load earlier in this period
            // takes effect here. A ratio loaded as zero mid-run ends the channel
            // after this terminal pulse instead of wrapping the counter.
            if (ratio_q != '0) begin
              cnt <= ratio_q - W'(1);
            end
            if (mode_q || (ratio_q == '0)) begin
              state <= ST_IDLE;
            end
          end else begin
            en_q <= 1'b0;
            cnt  <= cnt - W'(1);
          end
        end else begin
          en_q <= 1'b0;
        end
      end
    end

    assign bus.en[g]   = en_q;
    assign bus.busy[g] = (state == ST_RUN);
  end

endmodule

// File: tb/tb_prescaler_multi.sv
`timescale 1ns/1ps
// tb_prescaler_multi
//   Self-checking bench for prescaler_multi (CH=4, W=16, RATIO_RST=5, AUTORUN=1).
//   Expected en pulses are pushed to a scoreboard queue as (cycle, channel) when
//   stimulus is applied; every clock the entries due that cycle are retired and
//   compared with the full en vector, so missing and extra pulses both show up.
module tb_prescaler_multi;

  localparam int CH = 4;
  localparam int W  = 16;

  typedef struct {
    int unsigned cyc;
    int unsigned ch;
  } exp_t;

  logic        clk50m;
  logic        rst;
  int unsigned cyc;
  int unsigned checks;
  int unsigned errors;
  exp_t        exp_q[$];

  prescaler_multi_if #(.CH(CH), .W(W)) bus_if ();

  prescaler_multi #(
    .CH        (CH),
    .W         (W),
    .RATIO_RST (5),
    .AUTORUN   (1)
  ) dut (
    .clk50m (clk50m),
    .rst    (rst),
    .bus    (bus_if)
  );

  initial begin
    clk50m = 1'b0;
    forever #5 clk50m = ~clk50m;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d limit reached", cyc);
    $fatal(1, "timeout");
  end

  // cyc = number of posedges so far; en observed at the following negedge
  // belongs to edge cyc. Inputs set after this task are sampled at edge cyc+1.
  task automatic sb_tick();
    logic [CH-1:0] exp_v;
    @(negedge clk50m);
    exp_v = '0;
    for (int k = exp_q.size() - 1; k >= 0; k--) begin
      if (exp_q[k].cyc == cyc) begin
        exp_v[exp_q[k].ch] = 1'b1;
        exp_q.delete(k);
      end
    end
    checks++;
    if (bus_if.en !== exp_v) begin
      errors++;
      $display("FAIL sb_en cyc=%0d got=%b exp=%b", cyc, bus_if.en, exp_v);
    end
    @(posedge clk50m);
    #1;
    cyc++;
  endtask

  task automatic push(input int unsigned c, input int unsigned ch);
    exp_t e;
    e.cyc = c;
    e.ch  = ch;
    exp_q.push_back(e);
  endtask

  task automatic run_to(input int unsigned c);
    while (cyc < c) sb_tick();
  endtask

  task automatic set_ratio(input int unsigned ch, input logic [W-1:0] r);
    bus_if.ratio[ch*W +: W] = r;
  endtask

  // One-cycle strobes; sampled at edge cyc+1, cyc equals that edge on return.
  task automatic strobe(input logic [CH-1:0] ld, input logic [CH-1:0] st,
                        input logic [CH-1:0] sp, input logic sy);
    bus_if.load     = ld;
    bus_if.start    = st;
    bus_if.stop     = sp;
    bus_if.sync_all = sy;
    sb_tick();
    bus_if.load     = '0;
    bus_if.start    = '0;
    bus_if.stop     = '0;
    bus_if.sync_all = 1'b0;
  endtask

  task automatic test_reset();
    int unsigned e;
    run_to(3);
    checks++;
    if (bus_if.en !== 4'b0000) begin
      errors++;
      $display("FAIL reset_en got=%b exp=%b", bus_if.en, 4'b0000);
    end
    checks++;
    if (bus_if.busy !== 4'b1111) begin
      errors++;
      $display("FAIL reset_busy got=%b exp=%b", bus_if.busy, 4'b1111);
    end
    rst = 1'b0;
    e = cyc;
    for (int unsigned k = 1; k <= 3; k++)
      for (int unsigned ch = 0; ch < CH; ch++) push(e + 5 * k, ch);
    run_to(e + 16);
    strobe('0, '0, 4'b1111, 1'b0);
    checks++;
    if (bus_if.busy !== 4'b0000) begin
      errors++;
      $display("FAIL reset_stop_busy got=%b exp=%b", bus_if.busy, 4'b0000);
    end
  endtask

  task automatic test_load_running();
    int unsigned t;
    set_ratio(0, 16'd5);
    bus_if.mode[0] = 1'b0;
    strobe(4'b0001, 4'b0001, '0, 1'b0);
    t = cyc;
    push(t + 5, 0);
    push(t + 8, 0);
    push(t + 11, 0);
    push(t + 14, 0);
    run_to(t + 1);
    set_ratio(0, 16'd3);
    strobe(4'b0001, '0, '0, 1'b0);
    run_to(t + 15);
    strobe('0, '0, 4'b0001, 1'b0);
    checks++;
    if (bus_if.busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL load_run_stop busy0 got=%b exp=0", bus_if.busy[0]);
    end
  endtask

  task automatic test_one_shot();
    int unsigned t;
    set_ratio(1, 16'd4);
    bus_if.mode[1] = 1'b1;
    strobe(4'b0010, 4'b0010, '0, 1'b0);
    bus_if.mode[1] = 1'b0;
    t = cyc;
    push(t + 4, 1);
    run_to(t + 3);
    checks++;
    if (bus_if.busy[1] !== 1'b1) begin
      errors++;
      $display("FAIL oneshot_busy_before got=%b exp=1", bus_if.busy[1]);
    end
    sb_tick();
    checks++;
    if ({bus_if.busy[1], bus_if.en[1]} !== 2'b01) begin
      errors++;
      $display("FAIL oneshot_edge busy,en got=%b exp=01", {bus_if.busy[1], bus_if.en[1]});
    end
    run_to(t + 12);
    checks++;
    if (bus_if.busy[1] !== 1'b0) begin
      errors++;
      $display("FAIL oneshot_busy_after got=%b exp=0", bus_if.busy[1]);
    end
  endtask

  task automatic test_ratio_one_stop();
    int unsigned t;
    set_ratio(2, 16'd1);
    bus_if.mode[2] = 1'b0;
    strobe(4'b0100, 4'b0100, '0, 1'b0);
    t = cyc;
    for (int unsigned k = 1; k <= 5; k++) push(t + k, 2);
    run_to(t + 5);
    strobe('0, '0, 4'b0100, 1'b0);
    checks++;
    if ({bus_if.busy[2], bus_if.en[2]} !== 2'b00) begin
      errors++;
      $display("FAIL r1_stop busy,en got=%b exp=00", {bus_if.busy[2], bus_if.en[2]});
    end
    run_to(t + 10);
    checks++;
    if (bus_if.en[2] !== 1'b0) begin
      errors++;
      $display("FAIL r1_held en2 got=%b exp=0", bus_if.en[2]);
    end
  endtask

  task automatic test_sync_all();
    int unsigned t;
    set_ratio(3, 16'd7);
    bus_if.mode[3] = 1'b0;
    strobe(4'b1000, 4'b1001, '0, 1'b0);
    t = cyc;
    push(t + 3, 0);
    push(t + 7, 0);
    push(t + 10, 0);
    run_to(t + 1);
    strobe('0, '0, 4'b1000, 1'b0);
    run_to(t + 3);
    strobe('0, '0, '0, 1'b1);
    checks++;
    if (bus_if.busy !== 4'b0001) begin
      errors++;
      $display("FAIL sync_busy got=%b exp=%b", bus_if.busy, 4'b0001);
    end
    run_to(t + 10);
    strobe('0, '0, 4'b0001, 1'b0);
    checks++;
    if (bus_if.busy !== 4'b0000) begin
      errors++;
      $display("FAIL sync_stop_busy got=%b exp=%b", bus_if.busy, 4'b0000);
    end
  endtask

  task automatic test_zero_and_reset();
    int unsigned t;
    int unsigned e;
    set_ratio(1, 16'd0);
    bus_if.mode[1] = 1'b0;
    strobe(4'b0010, 4'b0010, '0, 1'b0);
    t = cyc;
    checks++;
    if (bus_if.busy[1] !== 1'b0) begin
      errors++;
      $display("FAIL r0_busy got=%b exp=0", bus_if.busy[1]);
    end
    run_to(t + 8);
    // ch0 still holds R=3, ch2 holds R=1 from earlier scenarios.
    strobe('0, 4'b0101, '0, 1'b0);
    t = cyc;
    push(t + 3, 0);
    for (int unsigned k = 1; k <= 4; k++) push(t + k, 2);
    run_to(t + 4);
    rst = 1'b1;
    sb_tick();
    rst = 1'b0;
    e = cyc;
    checks++;
    if (bus_if.en !== 4'b0000) begin
      errors++;
      $display("FAIL midrst_en got=%b exp=%b", bus_if.en, 4'b0000);
    end
    checks++;
    if (bus_if.busy !== 4'b1111) begin
      errors++;
      $display("FAIL midrst_busy got=%b exp=%b", bus_if.busy, 4'b1111);
    end
    for (int unsigned k = 1; k <= 2; k++)
      for (int unsigned ch = 0; ch < CH; ch++) push(e + 5 * k, ch);
    run_to(e + 11);
    strobe('0, '0, 4'b1111, 1'b0);
    checks++;
    if (bus_if.busy !== 4'b0000) begin
      errors++;
      $display("FAIL midrst_stop_busy got=%b exp=%b", bus_if.busy, 4'b0000);
    end
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    cyc             = 0;
    rst             = 1'b1;
    bus_if.ratio    = '0;
    bus_if.mode     = '0;
    bus_if.load     = '0;
    bus_if.start    = '0;
    bus_if.stop     = '0;
    bus_if.sync_all = 1'b0;
    @(posedge clk50m);
    #1;
    cyc = 1;

    test_reset();
    test_load_running();
    test_one_shot();
    test_ratio_one_stop();
    test_sync_all();
    test_zero_and_reset();
    run_to(cyc + 4);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover got=%0d exp=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
